// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 scan-code receiver.
//   ps2_state_e          : frame deserialiser states
//   PS2_BREAK_CODE       : break prefix byte (key release)
//   PS2_EXT_CODE         : extended-key prefix byte
//   PS2_*_DEFAULT        : default parameter values for the receiver
//   ps2_parity_ok()      : odd parity check over 8 data bits + parity bit
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    // 2 ms at 50 MHz with no falling edge aborts a partial frame.
    localparam int PS2_TIMEOUT_DEFAULT    = 100000;
    localparam int PS2_FILTER_DEFAULT     = 8;
    localparam int PS2_FIFO_DEPTH_DEFAULT = 8;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo -- synchronous show-ahead FIFO for received scan codes.
// Ports:
//   Clock, Reset       : system clock, asynchronous active-high reset
//   push, push_data    : write request and byte
//   pop                : remove head entry; ignored when empty
//   head               : current head entry, all zeros when empty
//   empty, full        : occupancy flags
//   overflow           : sticky, set when a push is refused because full
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module ps2_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A pop on an empty FIFO is ignored, so a simultaneous push just stores.
    // When full, a same-cycle pop frees the slot the push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver -- PS/2 keyboard front end.
// Synchronises and deglitches the PS/2 pins, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and buffers good bytes in a FIFO.
// Ports:
//   Clock, Reset  : 50 MHz system clock, asynchronous active-high reset
//   ps2_clk       : raw PS/2 clock pin (asynchronous)
//   ps2_data      : raw PS/2 data pin (asynchronous)
//   rd_en         : pop the FIFO head; ignored when empty
//   data          : FIFO head (show-ahead), 8'h00 when empty
//   data_valid    : FIFO non-empty
//   fifo_full     : FIFO holds FIFO_DEPTH entries
//   frame_error   : one-cycle pulse on start/parity/stop error or timeout abort
//   overflow      : sticky, a byte was dropped because the FIFO was full
//   state_dbg     : current deserialiser state
// Output handshake: the consumer may read `data` whenever data_valid=1; raising
// rd_en for one cycle while data_valid=1 consumes that entry and the next head
// (or 8'h00 / data_valid=0) is visible on the following cycle.
// Build option: define PS2_BREAK_FILTER_EN to drop break sequences (F0 xx) and
// E0 prefixes so only make codes reach the FIFO.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = PS2_FILTER_DEFAULT,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
    parameter int FIFO_DEPTH     = PS2_FIFO_DEPTH_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       fifo_full,
    output logic       frame_error,
    output logic       overflow,
    output ps2_state_e state_dbg
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

    // ---------------- pin synchronisers and clock filter ----------------
    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          clk_filt, clk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          strobe;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // The filtered clock only flips after FILTER_LEN consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign strobe = clk_filt_d && !clk_filt;

    // ---------------- frame deserialiser ----------------
    ps2_state_e    state, state_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift, shift_next;
    logic          parity, parity_next;
    logic [TW-1:0] to_cnt, to_cnt_next;
    logic          frame_ok;
    logic          err;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            parity      <= 1'b0;
            to_cnt      <= '0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            shift       <= shift_next;
            parity      <= parity_next;
            to_cnt      <= to_cnt_next;
            frame_error <= err;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        parity_next  = parity;
        frame_ok     = 1'b0;
        err          = 1'b0;

        // Counts cycles since the last strobe while a frame is in progress.
        if (state == IDLE || strobe) begin
            to_cnt_next = '0;
        end else begin
            to_cnt_next = to_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (strobe) begin
                    if (!dat_s2) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_next   = {dat_s2, shift[7:1]};
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (strobe) begin
                    parity_next = dat_s2;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    state_next = IDLE;
                    if (dat_s2 && ps2_parity_ok(shift, parity)) begin
                        frame_ok = 1'b1;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state != IDLE && !strobe && to_cnt == TO_LIMIT) begin
            state_next  = IDLE;
            to_cnt_next = '0;
            err         = 1'b1;
        end
    end

    assign state_dbg = state;

    // ---------------- optional break-code filter ----------------
    logic push;

`ifdef PS2_BREAK_FILTER_EN
    logic break_armed, break_armed_next;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            break_armed <= 1'b0;
        end else begin
            break_armed <= break_armed_next;
        end
    end

    // F0 arms a one-shot discard of the following key code; an E0 prefix in
    // between is itself discarded without consuming the armed discard.
    always_comb begin
        push             = 1'b0;
        break_armed_next = break_armed;
        if (frame_ok) begin
            if (shift == PS2_BREAK_CODE) begin
                break_armed_next = 1'b1;
            end else if (shift == PS2_EXT_CODE) begin
                break_armed_next = break_armed;
            end else if (break_armed) begin
                break_armed_next = 1'b0;
            end else begin
                push = 1'b1;
            end
        end
    end
`else
    assign push = frame_ok;
`endif

    // ---------------- scan-code buffer ----------------
    logic fifo_empty;

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (push),
        .push_data (shift),
        .pop       (rd_en),
        .head      (data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (overflow)
    );

    assign data_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
module tb_ps2_scan_receiver;
    import ps2_pkg::*;

    localparam int HALF       = 25;   // PS/2 half bit period in system clocks
    localparam int TB_TIMEOUT = 300;
    localparam int TB_DEPTH   = 8;

    // ---------------- clock / reset ----------------
    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data;
    logic       data_valid;
    logic       fifo_full;
    logic       frame_error;
    logic       overflow;
    ps2_state_e state_dbg;

    always #5 Clock = ~Clock;

    ps2_scan_receiver #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .FIFO_DEPTH     (TB_DEPTH)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rd_en       (rd_en),
        .data        (data),
        .data_valid  (data_valid),
        .fifo_full   (fifo_full),
        .frame_error (frame_error),
        .overflow    (overflow),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard / reference model ----------------
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         exp_overflow = 0;
    bit         model_armed = 0;
    int         exp_err = 0;

    // Monitor: frame_error pulses, pulses longer than one cycle, and the
    // state around each data_valid rising edge.
    int         err_pulses = 0;
    int         err_long = 0;
    logic       err_prev = 1'b0;
    logic       dv_prev = 1'b0;
    ps2_state_e st_prev = IDLE;
    ps2_state_e rise_prev_state = IDLE;
    ps2_state_e rise_state = IDLE;

    always @(negedge Clock) begin
        if (frame_error && !err_prev) err_pulses++;
        if (frame_error && err_prev) err_long++;
        err_prev = frame_error;
        if (data_valid && !dv_prev) begin
            rise_prev_state = st_prev;
            rise_state      = state_dbg;
        end
        dv_prev = data_valid;
        st_prev = state_dbg;
    end

    // A good byte as the keyboard-facing rules decide its fate.
    function automatic void model_byte(input logic [7:0] b);
`ifdef PS2_BREAK_FILTER_EN
        if (b == 8'hF0) begin
            model_armed = 1;
            return;
        end
        if (b == 8'hE0) return;
        if (model_armed) begin
            model_armed = 0;
            return;
        end
`endif
        if (exp_q.size() == TB_DEPTH) exp_overflow = 1;
        else exp_q.push_back(b);
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge Clock);
        Reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_en    = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        exp_q.delete();
        exp_overflow = 0;
        model_armed  = 0;
        repeat (2) @(negedge Clock);
    endtask

    // One PS/2 bit: data set while clock high, then a low phase. An optional
    // one-cycle glitch is placed in the middle of each phase.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        for (int i = 0; i < HALF; i++) begin
            @(negedge Clock);
            ps2_clk = (glitch && i == HALF / 2) ? 1'b0 : 1'b1;
        end
        ps2_clk = 1'b0;
        for (int i = 0; i < HALF; i++) begin
            @(negedge Clock);
            ps2_clk = (glitch && i == HALF / 2) ? 1'b1 : 1'b0;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit((~^b) ^ bad_par, glitch);
        ps2_bit(~bad_stop, glitch);
        ps2_data = 1'b1;
        repeat (20) @(negedge Clock);
        if (bad_par || bad_stop) exp_err++;
        else model_byte(b);
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (data_valid !== 1'b1 || data !== e) begin
                n_fail++;
                $display("FAIL %s_pop: got valid=%b data=%h, expected valid=1 data=%h",
                         tag, data_valid, data, e);
            end
            rd_en = 1'b1;
            @(negedge Clock);
            rd_en = 1'b0;
        end
        n_cmp++;
        if (data_valid !== 1'b0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_empty: got valid=%b data=%h, expected valid=0 data=00",
                     tag, data_valid, data);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({data, data_valid, fifo_full, frame_error, overflow} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h dv=%b full=%b err=%b ovf=%b, expected all 0",
                     data, data_valid, fifo_full, frame_error, overflow);
        end
        n_cmp++;
        if (state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, expected IDLE", state_dbg);
        end
    endtask

    task automatic test_single_byte();
        send_frame(8'h1C, 0, 0, 0);
        n_cmp++;
        if (rise_prev_state !== STOP || rise_state !== IDLE) begin
            n_fail++;
            $display("FAIL single_latency: states at data_valid rise %0d->%0d, expected STOP->IDLE",
                     rise_prev_state, rise_state);
        end
        n_cmp++;
        if (err_pulses !== exp_err) begin
            n_fail++;
            $display("FAIL single_err: got %0d pulses, expected %0d", err_pulses, exp_err);
        end
        drain("single");
    endtask

    task automatic test_frame_errors();
        send_frame(8'h1C, 1, 0, 0);
        n_cmp++;
        if (err_pulses !== exp_err || err_long !== 0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_err: got pulses=%0d long=%0d dv=%b, expected pulses=%0d long=0 dv=0",
                     err_pulses, err_long, data_valid, exp_err);
        end
        send_frame(8'hA5, 0, 1, 0);
        n_cmp++;
        if (err_pulses !== exp_err || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_err: got pulses=%0d dv=%b, expected pulses=%0d dv=0",
                     err_pulses, data_valid, exp_err);
        end
        // A falling edge with data high in IDLE is a bad start bit.
        ps2_bit(1'b1, 0);
        repeat (20) @(negedge Clock);
        exp_err++;
        n_cmp++;
        if (err_pulses !== exp_err || state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL start_err: got pulses=%0d state=%0d, expected pulses=%0d state=IDLE",
                     err_pulses, state_dbg, exp_err);
        end
    endtask

    task automatic test_timeout();
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        repeat (TB_TIMEOUT - 80) @(negedge Clock);
        n_cmp++;
        if (state_dbg !== DATA || err_pulses !== exp_err) begin
            n_fail++;
            $display("FAIL timeout_early: got state=%0d pulses=%0d, expected DATA pulses=%0d",
                     state_dbg, err_pulses, exp_err);
        end
        repeat (100) @(negedge Clock);
        exp_err++;
        n_cmp++;
        if (state_dbg !== IDLE || err_pulses !== exp_err || err_long !== 0) begin
            n_fail++;
            $display("FAIL timeout_abort: got state=%0d pulses=%0d long=%0d, expected IDLE %0d 0",
                     state_dbg, err_pulses, err_long, exp_err);
        end
        send_frame(8'h32, 0, 0, 0);
        drain("after_timeout");
    endtask

    task automatic test_glitch();
        send_frame(8'h5A, 0, 0, 1);
        send_frame(8'hC3, 0, 0, 1);
        n_cmp++;
        if (err_pulses !== exp_err) begin
            n_fail++;
            $display("FAIL glitch_err: got %0d pulses, expected %0d", err_pulses, exp_err);
        end
        drain("glitch");
    endtask

    task automatic test_break_seq();
        logic [7:0] seq [5];
        seq = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75};
        for (int i = 0; i < 5; i++) send_frame(seq[i], 0, 0, 0);
        drain("break_seq");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         kind;
        for (int i = 0; i < 7; i++) begin
            b    = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 4);
            send_frame(b, kind == 0, kind == 1, 0);
        end
        n_cmp++;
        if (err_pulses !== exp_err || overflow !== exp_overflow) begin
            n_fail++;
            $display("FAIL random_status: got pulses=%0d ovf=%b, expected %0d ovf=%b",
                     err_pulses, overflow, exp_err, exp_overflow);
        end
        drain("random");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
        n_cmp++;
        if (fifo_full !== (exp_q.size() == TB_DEPTH) || overflow !== exp_overflow) begin
            n_fail++;
            $display("FAIL overflow_flags: got full=%b ovf=%b, expected full=%b ovf=%b",
                     fifo_full, overflow, exp_q.size() == TB_DEPTH, exp_overflow);
        end
        drain("overflow");
        n_cmp++;
        if (overflow !== 1'b1 || fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_sticky: got ovf=%b full=%b, expected ovf=1 full=0",
                     overflow, fifo_full);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h11, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({data, data_valid, fifo_full, frame_error, overflow} !== 12'h000 ||
            state_dbg !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid: got data=%h dv=%b full=%b err=%b ovf=%b state=%0d, expected 0/IDLE",
                     data, data_valid, fifo_full, frame_error, overflow, state_dbg);
        end
        do_reset();
        send_frame(8'h4B, 0, 0, 0);
        drain("after_reset");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_byte();
        test_frame_errors();
        test_timeout();
        test_glitch();
        test_break_seq();
        test_random();
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
